// File: rtl/instr_decode_ctrl_pkg.sv
// Shared opcode, op-group and state definitions for the
// instruction controller and the ALU_16 datapath.
package instr_decode_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CL_WAIT,
    CL_ALU,
    CL_MOV,
    CL_CMP,
    CL_LOAD,
    CL_STORE
  } iclass_t;

  localparam logic [3:0] GRP_RTYPE = 4'b0000;
  localparam logic [3:0] GRP_MEM   = 4'b0100;
  localparam logic [3:0] GRP_SHIFT = 4'b1000;

  localparam logic [7:0] OP_WAIT  = 8'h00;
  localparam logic [7:0] OP_AND   = 8'h02;
  localparam logic [7:0] OP_OR    = 8'h03;
  localparam logic [7:0] OP_XOR   = 8'h04;
  localparam logic [7:0] OP_ADD   = 8'h05;
  localparam logic [7:0] OP_ADDU  = 8'h06;
  localparam logic [7:0] OP_ADDC  = 8'h07;
  localparam logic [7:0] OP_SUB   = 8'h09;
  localparam logic [7:0] OP_SUBC  = 8'h0A;
  localparam logic [7:0] OP_CMP   = 8'h0B;
  localparam logic [7:0] OP_CMPU  = 8'h0D;
  localparam logic [7:0] OP_MOV   = 8'h0E;
  localparam logic [7:0] OP_LOAD  = 8'h40;
  localparam logic [7:0] OP_STORE = 8'h44;
  localparam logic [7:0] OP_LSH   = 8'h84;
  localparam logic [7:0] OP_ASHU  = 8'h86;
  localparam logic [7:0] OP_LSHI  = 8'h80;

  localparam logic [3:0] OPI_ANDI  = 4'h1;
  localparam logic [3:0] OPI_ORI   = 4'h2;
  localparam logic [3:0] OPI_XORI  = 4'h3;
  localparam logic [3:0] OPI_ADDI  = 4'h5;
  localparam logic [3:0] OPI_ADDUI = 4'h6;
  localparam logic [3:0] OPI_ADDCI = 4'h7;
  localparam logic [3:0] OPI_SUBI  = 4'h9;
  localparam logic [3:0] OPI_SUBCI = 4'hA;
  localparam logic [3:0] OPI_CMPI  = 4'hB;
  localparam logic [3:0] OPI_MULI  = 4'hC;
  localparam logic [3:0] OPI_MOVI  = 4'hD;
  localparam logic [3:0] OPI_MULUI = 4'hE;
  localparam logic [3:0] OPI_LUI   = 4'hF;

  function automatic logic imm_signed(input logic [3:0] op);
    return op inside {OPI_ADDI, OPI_ADDCI, OPI_SUBI, OPI_CMPI};
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational field decode of one instruction word.
// Undefined encodings decode as WAIT with illegal raised.
module instr_field_decode
  import instr_decode_ctrl_pkg::*;
(
  input  logic [15:0] inst,
  output logic [7:0]  fullop,
  output logic [15:0] imm,
  output logic        muxb,
  output iclass_t     cls,
  output logic        illegal
);

  logic [3:0] op;
  logic [3:0] ext;

  assign op  = inst[15:12];
  assign ext = inst[7:4];

  always_comb begin
    fullop  = OP_WAIT;
    imm     = '0;
    muxb    = 1'b0;
    cls     = CL_WAIT;
    illegal = 1'b0;
    unique case (1'b1)
      (op == GRP_RTYPE): begin
        fullop = {op, ext};
        case ({op, ext})
          OP_WAIT: cls = CL_WAIT;
          OP_AND, OP_OR, OP_XOR, OP_ADD, OP_ADDU,
          OP_ADDC, OP_SUB, OP_SUBC: cls = CL_ALU;
          OP_CMP, OP_CMPU: cls = CL_CMP;
          OP_MOV: cls = CL_MOV;
          default: begin
            fullop  = OP_WAIT;
            illegal = 1'b1;
          end
        endcase
      end
      (op == GRP_MEM): begin
        case ({op, ext})
          OP_LOAD: begin
            fullop = OP_LOAD;
            cls    = CL_LOAD;
          end
          OP_STORE: begin
            fullop = OP_STORE;
            cls    = CL_STORE;
          end
          default: illegal = 1'b1;
        endcase
      end
      (op == GRP_SHIFT): begin
        if (ext[3:1] == 3'b000) begin
          fullop = {OP_LSHI[7:1], ext[0]};
          imm    = {12'b0, inst[3:0]};
          muxb   = 1'b1;
          cls    = CL_ALU;
        end else if ({op, ext} == OP_LSH ||
                     {op, ext} == OP_ASHU) begin
          fullop = {op, ext};
          cls    = CL_ALU;
        end else begin
          illegal = 1'b1;
        end
      end
      default: begin
        fullop = {op, 4'b0000};
        muxb   = 1'b1;
        imm    = imm_signed(op) ?
                 {{8{inst[7]}}, inst[7:0]} :
                 {8'b0, inst[7:0]};
        if (op == OPI_CMPI)
          cls = CL_CMP;
        else if (op == OPI_MOVI || op == OPI_LUI)
          cls = CL_MOV;
        else
          cls = CL_ALU;
      end
    endcase
  end

endmodule

// File: rtl/instr_decode_ctrl.sv
// Multi-cycle instruction controller: fetch, decode, execute,
// memory and write-back sequencing for the 16-bit datapath.
module instr_decode_ctrl
  import instr_decode_ctrl_pkg::*;
#(
  parameter bit STALL_ON_ILLEGAL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] inst_data,
  input  logic        inst_valid,
  output logic        inst_req,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [7:0]  FullOp,
  output logic [15:0] imm,
  output logic [3:0]  Rdest,
  output logic [3:0]  Rsrc,
  output logic        ctrlMuxB,
  output logic        Write,
  output logic        wb_sel,
  output logic        flag_en,
  output logic        illegal
);

  state_t      state;
  state_t      nxt;
  iclass_t     cls_q;
  logic [15:0] ir;

  logic [7:0]  d_fullop;
  logic [15:0] d_imm;
  logic        d_muxb;
  iclass_t     d_cls;
  logic        d_illegal;

  instr_field_decode u_dec (
    .inst    (ir),
    .fullop  (d_fullop),
    .imm     (d_imm),
    .muxb    (d_muxb),
    .cls     (d_cls),
    .illegal (d_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst)
      state <= S_FETCH;
    else
      state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ir       <= '0;
      cls_q    <= CL_WAIT;
      FullOp   <= '0;
      imm      <= '0;
      Rdest    <= '0;
      Rsrc     <= '0;
      ctrlMuxB <= 1'b0;
      wb_sel   <= 1'b0;
    end else begin
      if (state == S_FETCH && inst_valid)
        ir <= inst_data;
      // decoded fields stay frozen until the next DECODE
      if (state == S_DECODE) begin
        cls_q    <= d_cls;
        FullOp   <= d_fullop;
        imm      <= d_imm;
        Rdest    <= ir[11:8];
        Rsrc     <= ir[3:0];
        ctrlMuxB <= d_muxb;
        wb_sel   <= (d_cls == CL_LOAD);
      end
    end
  end

  always_comb begin
    nxt      = state;
    inst_req = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    Write    = 1'b0;
    flag_en  = 1'b0;
    illegal  = 1'b0;
    case (state)
      S_FETCH: begin
        inst_req = 1'b1;
        if (inst_valid)
          nxt = S_DECODE;
      end
      S_DECODE: begin
        illegal = d_illegal;
        if (d_illegal && STALL_ON_ILLEGAL)
          nxt = S_HALT;
        else
          nxt = S_EXEC;
      end
      S_EXEC: begin
        flag_en = (cls_q == CL_ALU) || (cls_q == CL_CMP);
        case (cls_q)
          CL_LOAD, CL_STORE: nxt = S_MEM;
          CL_ALU, CL_MOV:    nxt = S_WB;
          default:           nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls_q == CL_STORE);
        if (mem_ack)
          nxt = (cls_q == CL_LOAD) ? S_WB : S_FETCH;
      end
      S_WB: begin
        Write = 1'b1;
        nxt   = S_FETCH;
      end
      S_HALT: nxt = S_HALT;
      default: nxt = S_FETCH;
    endcase
  end

endmodule
